rosc_meas_ctrl: RTL and testbench
=================================

Name: rosc_meas_ctrl

Overview:
Parametrised measurement controller for a bank of NUM_CH ring-oscillator aging sensors. It replaces the fixed single-chain oscillator with selectable channels and two stress modes: DC hold or AC free-run. On request it enables one channel, lets it settle, counts its rising edges over a programmable window of CLK cycles, and returns the count through a valid/ready handshake. It sits between the oscillator bank and the odometer readout/register interface.

Parameters:
NUM_CH, 4, number of oscillator channels (>=1)
CH_W, 2, CH_SEL width; must satisfy 2**CH_W >= NUM_CH
CNT_W, 16, edge-count width
WIN_W, 16, window-length width
SETTLE_CYC, 8, CLK cycles an oscillator runs before counting starts (>=1)
SYNC_STAGES, 2, synchroniser depth on the selected oscillator output (>=2)

Ports:
CLK  in  1  system clock
RESETN  in  1  asynchronous active-low reset
START  in  1  measurement request; sampled only in IDLE
CH_SEL  in  CH_W  channel to measure; latched with START
WIN_LEN  in  WIN_W  count window in CLK cycles; latched with START
STRESS_AC  in  1  idle stress mode: 0 = DC (all oscillators disabled), 1 = AC (all oscillators running)
ROSC_OUT  in  NUM_CH  raw oscillator outputs, asynchronous to CLK
ROSC_EN  out  NUM_CH  registered oscillator enables
BUSY  out  1  high in SETTLE and COUNT
VALID  out  1  result available
READY  in  1  consumer accepts result
COUNT  out  CNT_W  edge count result
OVF  out  1  count saturated
ERR  out  1  CH_SEL was out of range

Behaviour:
- Reset (async assert, sync deassert handled upstream): state IDLE. ROSC_EN=0, BUSY=0, VALID=0, COUNT=0, OVF=0, ERR=0. All synchroniser and edge-detect flops cleared.
- FSM states: IDLE, SETTLE, COUNT, HOLD.
- IDLE:
  - ROSC_EN = {NUM_CH{STRESS_AC}}, registered, so a STRESS_AC change appears 1 cycle later.
  - START=1 latches CH_SEL and WIN_LEN.
  - If CH_SEL >= NUM_CH: go to HOLD with COUNT=0, OVF=0, ERR=1.
  - Otherwise go to SETTLE, clear the counter, OVF and ERR, and load the settle counter with SETTLE_CYC.
- SETTLE: ROSC_EN is one-hot on the latched channel (visible the cycle after START is sampled). Stay SETTLE_CYC cycles, then go to COUNT and load the window counter with WIN_LEN.
- WIN_LEN=0: SETTLE goes directly to HOLD with COUNT=0.
- COUNT:
  - ROSC_EN stays one-hot. Stay exactly WIN_LEN cycles.
  - Each cycle where the edge detector (synchronised sample AND NOT previous sample) is high increments the counter.
  - The counter saturates at 2**CNT_W-1; an increment attempted at saturation sets OVF.
  - After the last window cycle, go to HOLD.
- Synchroniser path: ROSC_OUT[latched channel] is muxed, then passed through SYNC_STAGES flops and one edge-detect flop. Synchroniser state is not cleared between measurements.
  - ROSC_OUT frequency must be below CLK/4; faster signals are out of scope.
- HOLD:
  - VALID=1. COUNT, OVF and ERR stay stable.
  - ROSC_EN returns to the idle stress pattern.
  - On VALID&&READY: VALID=0 next cycle and return to IDLE.
  - A START in the handshake cycle is ignored; START is accepted from the following cycle.
- Timing: with START sampled at cycle 0, VALID rises at cycle 1+SETTLE_CYC+WIN_LEN.
- BUSY = (state==SETTLE || state==COUNT).
- START outside IDLE is ignored. CH_SEL and WIN_LEN changes after latching have no effect.
- RESETN asserted mid-measurement: immediate return to reset values. The result is discarded and VALID stays low.
- COUNT and OVF keep the last result in IDLE until the next accepted START.

Test Plan:
- Reset, STRESS_AC=0, then STRESS_AC=1 -> ROSC_EN=0000, then 1111 one cycle after the change; VALID=0, COUNT=0.
- CH_SEL=2, WIN_LEN=64, ROSC_OUT[2] driven synchronously with period 8 CLK -> ROSC_EN=0100 during SETTLE/COUNT; VALID at cycle 73; COUNT=8, OVF=0, ERR=0. Toggling other channels does not change the result.
- CNT_W=4, period 4, WIN_LEN=100 -> COUNT=15, OVF=1.
- CH_SEL=5 with NUM_CH=4 -> VALID at cycle 1, ERR=1, COUNT=0, ROSC_EN never one-hot. WIN_LEN=0 on a valid channel -> VALID at cycle 1+SETTLE_CYC, COUNT=0.
- READY held low 20 cycles -> VALID and COUNT stable, extra START pulses ignored. READY=1 -> VALID=0 next cycle; START the cycle after is accepted.
- RESETN pulsed low in the middle of COUNT -> outputs at reset values immediately; a new START then measures normally with COUNT=8.

Source files
------------

// File: rtl/rosc_meas_ctrl.sv
// Ring-oscillator aging-sensor measurement: settle, count edges over WIN_LEN cycles, return result.
// VALID rises 1+SETTLE_CYC+WIN_LEN cycles after START; the result is held in HOLD until READY.
module rosc_meas_ctrl #(
   parameter int NUM_CH      = 4,
   parameter int CH_W        = 2,
   parameter int CNT_W       = 16,
   parameter int WIN_W       = 16,
   parameter int SETTLE_CYC  = 8,
   parameter int SYNC_STAGES = 2
) (
   input  logic              CLK,
   input  logic              RESETN,
   input  logic              START,
   input  logic [CH_W-1:0]   CH_SEL,
   input  logic [WIN_W-1:0]  WIN_LEN,
   input  logic              STRESS_AC,
   input  logic [NUM_CH-1:0] ROSC_OUT,
   output logic [NUM_CH-1:0] ROSC_EN,
   output logic              BUSY,
   output logic              VALID,
   input  logic              READY,
   output logic [CNT_W-1:0]  COUNT,
   output logic              OVF,
   output logic              ERR
);

   localparam int SW = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
   localparam int TW = (WIN_W > SW) ? WIN_W : SW;
   localparam logic [CH_W:0] NUM_CH_L = (CH_W+1)'(NUM_CH);

   typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_COUNT, S_HOLD} state_t;

   state_t                r_state, w_nxt;
   logic [CH_W-1:0]       r_ch;
   logic [WIN_W-1:0]      r_win;
   logic [TW-1:0]         r_tmr;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_ovf, r_err;
   logic [NUM_CH-1:0]     r_en;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                  r_prev;

   logic                  w_start, w_bad, w_tmr_last, w_raw, w_edge;
   logic [CH_W-1:0]       w_ch_nxt;
   logic [NUM_CH-1:0]     w_en_nxt;

   assign w_start    = (r_state == S_IDLE) && START;
   assign w_bad      = ({1'b0, CH_SEL} >= NUM_CH_L);
   assign w_tmr_last = (r_tmr == TW'(1));
   assign w_edge     = r_sync[SYNC_STAGES-1] & ~r_prev;
   assign w_ch_nxt   = w_start ? CH_SEL : r_ch;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) r_state <= S_IDLE;
      else         r_state <= w_nxt;
   end

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         S_IDLE:   if (START) w_nxt = w_bad ? S_HOLD : S_SETTLE;
         S_SETTLE: if (w_tmr_last) w_nxt = (r_win == '0) ? S_HOLD : S_COUNT;
         S_COUNT:  if (w_tmr_last) w_nxt = S_HOLD;
         S_HOLD:   if (READY) w_nxt = S_IDLE;
         default:  w_nxt = S_IDLE;
      endcase
   end

   // Enables follow the next state so the one-hot pattern lines up with SETTLE/COUNT.
   always_comb begin
      w_en_nxt = {NUM_CH{STRESS_AC}};
      if (w_nxt == S_SETTLE || w_nxt == S_COUNT) begin
         for (int i = 0; i < NUM_CH; i++) w_en_nxt[i] = (w_ch_nxt == CH_W'(i));
      end
   end

   always_comb begin
      w_raw = 1'b0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (r_ch == CH_W'(i)) w_raw = ROSC_OUT[i];
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_sync <= '0;
         r_prev <= 1'b0;
         r_en   <= '0;
      end else begin
         r_sync <= {r_sync[SYNC_STAGES-2:0], w_raw};
         r_prev <= r_sync[SYNC_STAGES-1];
         r_en   <= w_en_nxt;
      end
   end

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_ch  <= '0;
         r_win <= '0;
         r_tmr <= '0;
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_err <= 1'b0;
      end else if (w_start) begin
         r_ch  <= CH_SEL;
         r_win <= WIN_LEN;
         r_tmr <= TW'(SETTLE_CYC);
         r_cnt <= '0;
         r_ovf <= 1'b0;
         r_err <= w_bad;
      end else begin
         case (r_state)
            S_SETTLE: r_tmr <= w_tmr_last ? TW'(r_win) : r_tmr - TW'(1);
            S_COUNT: begin
               r_tmr <= r_tmr - TW'(1);
               if (w_edge) begin
                  if (r_cnt == {CNT_W{1'b1}}) r_ovf <= 1'b1;
                  else                        r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign ROSC_EN = r_en;
   assign BUSY    = (r_state == S_SETTLE) || (r_state == S_COUNT);
   assign VALID   = (r_state == S_HOLD);
   assign COUNT   = r_cnt;
   assign OVF     = r_ovf;
   assign ERR     = r_err;

endmodule

// File: tb/tb_rosc_meas_ctrl.sv
// Directed bench: two instances (3-bit CH_SEL for out-of-range, 4-bit counter for saturation).
module tb_rosc_meas_ctrl;
   logic        clk = 1'b0;
   logic        rstn, start, start_b, stress, ready, ready_b;
   logic [2:0]  ch;
   logic [15:0] win;
   logic [3:0]  rosc;
   logic [3:0]  en_a, en_b;
   logic        busy_a, busy_b, vld_a, vld_b, ovf_a, ovf_b, err_a, err_b;
   logic [15:0] cnt_a;
   logic [3:0]  cnt_b;
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          period = 8;

   always #5 clk = ~clk;

   rosc_meas_ctrl #(.NUM_CH(4), .CH_W(3), .CNT_W(16), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut_a (
      .CLK(clk), .RESETN(rstn), .START(start), .CH_SEL(ch), .WIN_LEN(win), .STRESS_AC(stress),
      .ROSC_OUT(rosc), .ROSC_EN(en_a), .BUSY(busy_a), .VALID(vld_a), .READY(ready),
      .COUNT(cnt_a), .OVF(ovf_a), .ERR(err_a));

   rosc_meas_ctrl #(.NUM_CH(4), .CH_W(2), .CNT_W(4), .WIN_W(16), .SETTLE_CYC(8), .SYNC_STAGES(2)) dut_b (
      .CLK(clk), .RESETN(rstn), .START(start_b), .CH_SEL(ch[1:0]), .WIN_LEN(win), .STRESS_AC(stress),
      .ROSC_OUT(rosc), .ROSC_EN(en_b), .BUSY(busy_b), .VALID(vld_b), .READY(ready_b),
      .COUNT(cnt_b), .OVF(ovf_b), .ERR(err_b));

   // Channel 2 is a synchronous square wave; the other channels toggle as interference.
   initial begin
      rosc = 4'b0000;
      forever begin
         @(posedge clk);
         #2;
         cyc++;
         rosc[2] = ((cyc % period) < (period / 2));
         rosc[0] = ((cyc % 6) < 3);
         rosc[1] = ((cyc % 10) < 5);
         rosc[3] = ((cyc % 14) < 7);
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rstn = 1'b0; start = 1'b0; start_b = 1'b0; stress = 1'b0;
      ready = 1'b0; ready_b = 1'b0; ch = 3'd0; win = 16'd0;
      tick(2);
      chk("rst_en", en_a, 4'h0);
      chk("rst_valid", vld_a, 1'b0);
      chk("rst_count", cnt_a, 16'd0);
      chk("rst_busy", busy_a, 1'b0);
      chk("rst_ovf_err", {ovf_a, err_a}, 2'b00);
      chk("rst_b", {vld_b, cnt_b, ovf_b}, 6'd0);
      rstn = 1'b1;
      tick(1);

      // Idle stress pattern is registered
      stress = 1'b1;
      #1 chk("stress_not_yet", en_a, 4'h0);
      tick(1);
      chk("stress_ac_en", en_a, 4'hF);
      stress = 1'b0;
      tick(1);
      chk("stress_dc_en", en_a, 4'h0);

      // Out-of-range channel: straight to HOLD with ERR
      stress = 1'b1; ch = 3'd5; win = 16'd10; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("err_valid_c1", vld_a, 1'b1);
      chk("err_flag", err_a, 1'b1);
      chk("err_count", cnt_a, 16'd0);
      chk("err_en_stress", en_a, 4'hF);
      chk("err_busy", busy_a, 1'b0);
      ready = 1'b1;
      tick(1);
      ready = 1'b0; stress = 1'b0;
      chk("err_ack", vld_a, 1'b0);

      // WIN_LEN=0: VALID at 1+SETTLE_CYC with COUNT=0
      ch = 3'd1; win = 16'd0; start = 1'b1;
      tick(1);
      start = 1'b0;
      chk("w0_en", en_a, 4'h2);
      chk("w0_busy", busy_a, 1'b1);
      chk("w0_err_clr", err_a, 1'b0);
      tick(7);
      chk("w0_not_valid", vld_a, 1'b0);
      tick(1);
      chk("w0_valid", vld_a, 1'b1);
      chk("w0_count", cnt_a, 16'd0);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;

      // Saturation on the 4-bit instance: 25 edges in 100 cycles
      period = 4; ch = 3'd2; win = 16'd100; start_b = 1'b1;
      tick(1);
      start_b = 1'b0;
      chk("ovf_en", en_b, 4'h4);
      tick(107);
      chk("ovf_not_valid", vld_b, 1'b0);
      tick(1);
      chk("ovf_valid", vld_b, 1'b1);
      chk("ovf_count", cnt_b, 4'hF);
      chk("ovf_flag", ovf_b, 1'b1);
      chk("ovf_a_idle", vld_a, 1'b0);
      ready_b = 1'b1;
      tick(1);
      ready_b = 1'b0;
      chk("ovf_ack", vld_b, 1'b0);
      period = 8;
      tick(10);

      // Main measurement: ch 2, period 8, window 64
      ch = 3'd2; win = 16'd64; start = 1'b1;
      tick(1);
      start = 1'b0; ch = 3'd0; win = 16'd5;
      chk("m_busy", busy_a, 1'b1);
      chk("m_en_settle", en_a, 4'h4);
      tick(8);
      chk("m_en_count", en_a, 4'h4);
      chk("m_busy_count", busy_a, 1'b1);
      tick(63);
      chk("m_not_valid_72", vld_a, 1'b0);
      tick(1);
      chk("m_valid_73", vld_a, 1'b1);
      chk("m_count", cnt_a, 16'd8);
      chk("m_ovf_err", {ovf_a, err_a}, 2'b00);
      chk("m_en_hold", en_a, 4'h0);
      chk("m_busy_hold", busy_a, 1'b0);

      // Backpressure: result stable, START ignored
      for (int i = 0; i < 20; i++) begin
         start = (i % 5 == 0);
         tick(1);
      end
      start = 1'b0;
      chk("bp_valid", vld_a, 1'b1);
      chk("bp_count", cnt_a, 16'd8);
      chk("bp_busy", busy_a, 1'b0);

      // START in handshake cycle ignored, accepted the cycle after
      ch = 3'd2; win = 16'd64; ready = 1'b1; start = 1'b1;
      tick(1);
      ready = 1'b0;
      chk("hs_valid_low", vld_a, 1'b0);
      chk("hs_start_ignored", busy_a, 1'b0);
      chk("hs_count_kept", cnt_a, 16'd8);
      tick(1);
      start = 1'b0;
      chk("hs_start_taken", busy_a, 1'b1);
      tick(71);
      chk("hs_not_valid", vld_a, 1'b0);
      tick(1);
      chk("hs_valid", vld_a, 1'b1);
      chk("hs_count", cnt_a, 16'd8);
      ready = 1'b1;
      tick(1);
      ready = 1'b0;
      tick(1);
      chk("idle_keeps_count", cnt_a, 16'd8);

      // Reset in the middle of COUNT
      start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(40);
      chk("mid_busy", busy_a, 1'b1);
      rstn = 1'b0;
      #1;
      chk("mid_rst_busy", busy_a, 1'b0);
      chk("mid_rst_en", en_a, 4'h0);
      chk("mid_rst_count", cnt_a, 16'd0);
      chk("mid_rst_valid", vld_a, 1'b0);
      tick(1);
      rstn = 1'b1;
      tick(3);
      chk("post_rst_valid", vld_a, 1'b0);
      ch = 3'd2; win = 16'd64; start = 1'b1;
      tick(1);
      start = 1'b0;
      tick(71);
      chk("post_rst_not_valid", vld_a, 1'b0);
      tick(1);
      chk("post_rst_valid_hi", vld_a, 1'b1);
      chk("post_rst_count", cnt_a, 16'd8);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
